// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: ID/EX register, operand
// forwarding, ALU, branch/jump resolution and the EX/MEM register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall_e, flush_e           hazard unit: hold ID/EX / load bubble (flush wins)
//   *_d                        decoded controls, operands and register indices
//   forward_ae, forward_be     operand select: 00 reg, 01 result_w, 10 alu_result_m
//   result_w                   writeback-stage result for forwarding
//   rs1_e, rs2_e, rd_e         E-stage indices to hazard unit
//   resultsrc_e0               E-stage resultsrc[0] for load-use detection
//   pcsrc_e, pctarget_e        fetch redirect and its target
//   *_m                        EX/MEM register contents for the memory stage

package execute_stage_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       branch;
      logic       jump;
      logic       alusrc;
      logic [1:0] resultsrc;
      logic [2:0] alucontrol;
   } ctrl_e_t;

   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic [1:0] resultsrc;
   } ctrl_m_t;

endpackage

module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_e,
   input  logic            flush_e,
   input  logic            regwrite_d,
   input  logic            memwrite_d,
   input  logic            branch_d,
   input  logic            jump_d,
   input  logic            alusrc_d,
   input  logic [1:0]      resultsrc_d,
   input  logic [2:0]      alucontrol_d,
   input  logic [XLEN-1:0] rd1_d,
   input  logic [XLEN-1:0] rd2_d,
   input  logic [XLEN-1:0] imm_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pcplus4_d,
   input  logic [4:0]      rs1_d,
   input  logic [4:0]      rs2_d,
   input  logic [4:0]      rd_d,
   input  logic [1:0]      forward_ae,
   input  logic [1:0]      forward_be,
   input  logic [XLEN-1:0] result_w,
   output logic [4:0]      rs1_e,
   output logic [4:0]      rs2_e,
   output logic [4:0]      rd_e,
   output logic            resultsrc_e0,
   output logic            pcsrc_e,
   output logic [XLEN-1:0] pctarget_e,
   output logic            regwrite_m,
   output logic            memwrite_m,
   output logic [1:0]      resultsrc_m,
   output logic [XLEN-1:0] alu_result_m,
   output logic [XLEN-1:0] write_data_m,
   output logic [XLEN-1:0] pcplus4_m,
   output logic [4:0]      rd_m
);

   // ID/EX register contents
   ctrl_e_t         ctrl_e;
   logic [XLEN-1:0] rd1_e;
   logic [XLEN-1:0] rd2_e;
   logic [XLEN-1:0] imm_e;
   logic [XLEN-1:0] pc_e;
   logic [XLEN-1:0] pcplus4_e;

   // EX/MEM control fields
   ctrl_m_t         ctrl_m;

   // E-stage combinational values
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] write_data_e;
   logic [XLEN-1:0] srcb;
   logic [XLEN-1:0] alu_result_e;
   logic            zero_e;

   // ID/EX register: flush inserts a bubble and beats stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_e    <= '0;
         rd1_e     <= '0;
         rd2_e     <= '0;
         imm_e     <= '0;
         pc_e      <= '0;
         pcplus4_e <= '0;
         rs1_e     <= '0;
         rs2_e     <= '0;
         rd_e      <= '0;
      end else if (flush_e) begin
         ctrl_e    <= '0;
         rd1_e     <= '0;
         rd2_e     <= '0;
         imm_e     <= '0;
         pc_e      <= '0;
         pcplus4_e <= '0;
         rs1_e     <= '0;
         rs2_e     <= '0;
         rd_e      <= '0;
      end else if (!stall_e) begin
         ctrl_e.regwrite   <= regwrite_d;
         ctrl_e.memwrite   <= memwrite_d;
         ctrl_e.branch     <= branch_d;
         ctrl_e.jump       <= jump_d;
         ctrl_e.alusrc     <= alusrc_d;
         ctrl_e.resultsrc  <= resultsrc_d;
         ctrl_e.alucontrol <= alucontrol_d;
         rd1_e             <= rd1_d;
         rd2_e             <= rd2_d;
         imm_e             <= imm_d;
         pc_e              <= pc_d;
         pcplus4_e         <= pcplus4_d;
         rs1_e             <= rs1_d;
         rs2_e             <= rs2_d;
         rd_e              <= rd_d;
      end
   end

   // Forwarding muxes; the unused code 11 falls back to the register value
   always_comb begin
      srca = rd1_e;
      case (forward_ae)
         FWD_REG: srca = rd1_e;
         FWD_WB:  srca = result_w;
         FWD_MEM: srca = alu_result_m;
         default: srca = rd1_e;
      endcase
   end

   always_comb begin
      write_data_e = rd2_e;
      case (forward_be)
         FWD_REG: write_data_e = rd2_e;
         FWD_WB:  write_data_e = result_w;
         FWD_MEM: write_data_e = alu_result_m;
         default: write_data_e = rd2_e;
      endcase
   end

   assign srcb = ctrl_e.alusrc ? imm_e : write_data_e;

   // ALU with wrap-around arithmetic; unassigned codes yield 0
   always_comb begin
      alu_result_e = '0;
      case (ctrl_e.alucontrol)
         ALU_ADD: alu_result_e = srca + srcb;
         ALU_SUB: alu_result_e = srca - srcb;
         ALU_AND: alu_result_e = srca & srcb;
         ALU_OR:  alu_result_e = srca | srcb;
         ALU_XOR: alu_result_e = srca ^ srcb;
         ALU_SLT: alu_result_e = XLEN'($signed(srca) < $signed(srcb));
         default: alu_result_e = '0;
      endcase
   end

   assign zero_e       = (alu_result_e == '0);
   assign pctarget_e   = pc_e + imm_e;
   assign pcsrc_e      = (ctrl_e.branch & zero_e) | ctrl_e.jump;
   assign resultsrc_e0 = ctrl_e.resultsrc[0];

   // EX/MEM register: captures every cycle, so bubbles arrive as zero controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_m       <= '0;
         alu_result_m <= '0;
         write_data_m <= '0;
         pcplus4_m    <= '0;
         rd_m         <= '0;
      end else begin
         ctrl_m.regwrite  <= ctrl_e.regwrite;
         ctrl_m.memwrite  <= ctrl_e.memwrite;
         ctrl_m.resultsrc <= ctrl_e.resultsrc;
         alu_result_m     <= alu_result_e;
         write_data_m     <= write_data_e;
         pcplus4_m        <= pcplus4_e;
         rd_m             <= rd_e;
      end
   end

   assign regwrite_m  = ctrl_m.regwrite;
   assign memwrite_m  = ctrl_m.memwrite;
   assign resultsrc_m = ctrl_m.resultsrc;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a reference model predicts E-stage
// and EX/MEM outputs per cycle; two monitors pop and compare.
module tb_execute_stage;

   typedef struct packed {
      logic        regwrite;
      logic        memwrite;
      logic        branch;
      logic        jump;
      logic        alusrc;
      logic [1:0]  resultsrc;
      logic [2:0]  alucontrol;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcplus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } instr_t;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        resultsrc0;
      logic        pcsrc;
      logic [31:0] pctarget;
   } e_exp_t;

   typedef struct packed {
      logic        regwrite;
      logic        memwrite;
      logic [1:0]  resultsrc;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [31:0] pcplus4;
      logic [4:0]  rd;
   } m_exp_t;

   logic        clk;
   logic        rst_n;
   logic        stall_e, flush_e;
   logic        regwrite_d, memwrite_d, branch_d, jump_d, alusrc_d;
   logic [1:0]  resultsrc_d;
   logic [2:0]  alucontrol_d;
   logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pcplus4_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [1:0]  forward_ae, forward_be;
   logic [31:0] result_w;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic        resultsrc_e0, pcsrc_e;
   logic [31:0] pctarget_e;
   logic        regwrite_m, memwrite_m;
   logic [1:0]  resultsrc_m;
   logic [31:0] alu_result_m, write_data_m, pcplus4_m;
   logic [4:0]  rd_m;

   int tests = 0;
   int fails = 0;

   // Model state: the instruction occupying E and the value expected in M
   instr_t      e_instr;
   logic [31:0] m_alu;
   e_exp_t      e_q[$];
   m_exp_t      m_q[$];

   execute_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
      .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
      .jump_d(jump_d), .alusrc_d(alusrc_d), .resultsrc_d(resultsrc_d),
      .alucontrol_d(alucontrol_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
      .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .forward_ae(forward_ae), .forward_be(forward_be), .result_w(result_w),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .resultsrc_e0(resultsrc_e0),
      .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e), .regwrite_m(regwrite_m),
      .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m),
      .alu_result_m(alu_result_m), .write_data_m(write_data_m),
      .pcplus4_m(pcplus4_m), .rd_m(rd_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'b10) return m;
      if (sel == 2'b01) return w;
      return r;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Drive one cycle at the falling edge and record what the model predicts
   task automatic step(input instr_t d, input logic st, input logic fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw);
      e_exp_t ee;
      m_exp_t me;
      logic [31:0] a, wd, b, r;
      @(negedge clk);
      rst_n = 1'b1;
      regwrite_d = d.regwrite; memwrite_d = d.memwrite; branch_d = d.branch;
      jump_d = d.jump; alusrc_d = d.alusrc; resultsrc_d = d.resultsrc;
      alucontrol_d = d.alucontrol; rd1_d = d.rd1; rd2_d = d.rd2; imm_d = d.imm;
      pc_d = d.pc; pcplus4_d = d.pcplus4; rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd;
      stall_e = st; flush_e = fl; forward_ae = fa; forward_be = fb; result_w = rw;

      a  = fwd(fa, e_instr.rd1, rw, m_alu);
      wd = fwd(fb, e_instr.rd2, rw, m_alu);
      b  = e_instr.alusrc ? e_instr.imm : wd;
      r  = alu(e_instr.alucontrol, a, b);

      ee.rs1 = e_instr.rs1; ee.rs2 = e_instr.rs2; ee.rd = e_instr.rd;
      ee.resultsrc0 = e_instr.resultsrc[0];
      ee.pcsrc      = (e_instr.branch && r == 32'd0) || e_instr.jump;
      ee.pctarget   = e_instr.pc + e_instr.imm;
      e_q.push_back(ee);

      me.regwrite = e_instr.regwrite; me.memwrite = e_instr.memwrite;
      me.resultsrc = e_instr.resultsrc; me.alu = r; me.wd = wd;
      me.pcplus4 = e_instr.pcplus4; me.rd = e_instr.rd;
      m_q.push_back(me);

      m_alu = r;
      if (fl)       e_instr = '0;
      else if (!st) e_instr = d;
   endtask

   function automatic instr_t rand_instr();
      instr_t t;
      t.regwrite   = 1'($urandom);
      t.memwrite   = 1'($urandom);
      t.branch     = 1'($urandom);
      t.jump       = ($urandom_range(0, 4) == 0);
      t.alusrc     = 1'($urandom);
      t.resultsrc  = 2'($urandom);
      t.alucontrol = 3'($urandom);
      t.rd1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      t.rd2        = ($urandom_range(0, 2) == 0) ? t.rd1 : $urandom;
      t.imm        = $urandom;
      t.pc         = $urandom;
      t.pcplus4    = t.pc + 32'd4;
      t.rs1        = 5'($urandom);
      t.rs2        = 5'($urandom);
      t.rd         = 5'($urandom);
      return t;
   endfunction

   // Monitor for E-stage outputs, sampled after inputs settle
   initial begin
      e_exp_t ee;
      forever begin
         @(negedge clk);
         #2;
         if (e_q.size() != 0) begin
            ee = e_q.pop_front();
            check("rs1_e", 32'(rs1_e), 32'(ee.rs1));
            check("rs2_e", 32'(rs2_e), 32'(ee.rs2));
            check("rd_e", 32'(rd_e), 32'(ee.rd));
            check("resultsrc_e0", 32'(resultsrc_e0), 32'(ee.resultsrc0));
            check("pcsrc_e", 32'(pcsrc_e), 32'(ee.pcsrc));
            check("pctarget_e", pctarget_e, ee.pctarget);
         end
      end
   end

   // Monitor for EX/MEM outputs, sampled just after the capturing edge
   initial begin
      m_exp_t me;
      forever begin
         @(posedge clk);
         #1;
         if (m_q.size() != 0) begin
            me = m_q.pop_front();
            check("regwrite_m", 32'(regwrite_m), 32'(me.regwrite));
            check("memwrite_m", 32'(memwrite_m), 32'(me.memwrite));
            check("resultsrc_m", 32'(resultsrc_m), 32'(me.resultsrc));
            check("alu_result_m", alu_result_m, me.alu);
            check("write_data_m", write_data_m, me.wd);
            check("pcplus4_m", pcplus4_m, me.pcplus4);
            check("rd_m", 32'(rd_m), 32'(me.rd));
         end
      end
   end

   task automatic alu_case(input string name, input instr_t t, input logic [31:0] exp);
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      @(posedge clk);
      #1;
      check(name, alu_result_m, exp);
   endtask

   initial begin
      instr_t t, u;
      e_instr = '0;
      m_alu   = '0;
      rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
      regwrite_d = 1'b1; memwrite_d = 1'b0; branch_d = 1'b0; jump_d = 1'b0;
      alusrc_d = 1'b0; resultsrc_d = 2'b00; alucontrol_d = 3'b000;
      rd1_d = 32'd0; rd2_d = 32'd0; imm_d = 32'd0; pc_d = 32'd0; pcplus4_d = 32'd0;
      rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0;
      forward_ae = 2'b00; forward_be = 2'b00; result_w = 32'd0;
      #3;
      check("reset regwrite_m", 32'(regwrite_m), 32'd0);
      check("reset alu_result_m", alu_result_m, 32'd0);
      check("reset pcsrc_e", 32'(pcsrc_e), 32'd0);
      check("reset rd_e", 32'(rd_e), 32'd0);

      // ADD with forwarding from the memory stage: 5 + 7
      t = '0; t.regwrite = 1'b1; t.rd1 = 32'd7; t.rd = 5'd1;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      t = '0; t.regwrite = 1'b1; t.rd1 = 32'd5; t.rd = 5'd2;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b10, 32'd0);
      @(posedge clk);
      #1;
      check("add fwd", alu_result_m, 32'd12);

      // BEQ taken and not taken
      t = '0; t.branch = 1'b1; t.alucontrol = 3'b001; t.rd1 = 32'h1234;
      t.rd2 = 32'h1234; t.pc = 32'h100; t.imm = 32'h20;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      #1;
      check("beq taken pcsrc", 32'(pcsrc_e), 32'd1);
      check("beq pctarget", pctarget_e, 32'h120);
      t.rd2 = 32'h1235;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      #1;
      check("beq not taken pcsrc", 32'(pcsrc_e), 32'd0);

      // ALU corner cases
      t = '0; t.alucontrol = 3'b101; t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1;
      alu_case("slt neg<pos", t, 32'd1);
      t.rd1 = 32'd1; t.rd2 = 32'hFFFF_FFFF;
      alu_case("slt pos<neg", t, 32'd0);
      t = '0; t.alucontrol = 3'b100; t.rd1 = 32'hF0F0; t.rd2 = 32'h0FF0;
      alu_case("xor", t, 32'hFF00);
      t.alucontrol = 3'b111;
      alu_case("code 111", t, 32'd0);
      t = '0; t.alusrc = 1'b1; t.imm = 32'hFFFF_FFFC; t.rd1 = 32'd8; t.rd2 = 32'h55;
      alu_case("add imm", t, 32'd4);
      check("write_data not imm", write_data_m, 32'h55);

      // Stall holds E, stall+flush inserts a bubble
      t = '0; t.regwrite = 1'b1; t.alucontrol = 3'b011; t.rd = 5'd9;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      u = rand_instr(); u.rd = 5'd3;
      step(u, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
      step(u, 1'b1, 1'b0, 2'b00, 2'b00, 32'd0);
      #1;
      check("stall rd_e", 32'(rd_e), 32'd9);
      step(u, 1'b1, 1'b1, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      @(posedge clk);
      #1;
      check("flush regwrite_m", 32'(regwrite_m), 32'd0);

      // Jump flushed on entry never redirects
      t = '0; t.jump = 1'b1; t.pc = 32'h40; t.imm = 32'h8;
      step(t, 1'b0, 1'b1, 2'b00, 2'b00, 32'd0);
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      #1;
      check("flushed jump pcsrc", 32'(pcsrc_e), 32'd0);

      // Mid-stream asynchronous reset
      t = '0; t.regwrite = 1'b1; t.rd1 = 32'd3; t.rd = 5'd4;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      t = '0; t.regwrite = 1'b1; t.jump = 1'b1; t.rd1 = 32'd6;
      step(t, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      @(negedge clk);
      #1;
      check("pre-reset pcsrc_e", 32'(pcsrc_e), 32'd1);
      rst_n = 1'b0;
      regwrite_d = 1'b1;
      #1;
      check("mid reset regwrite_m", 32'(regwrite_m), 32'd0);
      check("mid reset alu_result_m", alu_result_m, 32'd0);
      check("mid reset pcsrc_e", 32'(pcsrc_e), 32'd0);
      e_instr = '0;
      m_alu   = '0;

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step(rand_instr(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
              2'($urandom), 2'($urandom), $urandom);
      end
      step('0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      check("e queue drained", 32'(e_q.size()), 32'd0);
      check("m queue drained", 32'(m_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage pipelined RV32I core; sits directly downstream of the ALU decoder and main decoder.
- Contains the ID/EX pipeline register (decoded operands plus ALUControl), the operand forwarding muxes, and the ALU.
- Resolves branches and jumps in E and drives the EX/MEM pipeline register consumed by the memory stage.
- Supports stall (hold) and flush (bubble insertion) driven by the hazard unit.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall_e  input  1  hold ID/EX contents
- flush_e  input  1  load a bubble into ID/EX
- regwrite_d, memwrite_d, branch_d, jump_d, alusrc_d  input  1 each  decoded controls
- resultsrc_d  input  2  result select (00 ALU, 01 mem, 10 PC+4)
- alucontrol_d  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
- rd1_d, rd2_d, imm_d, pc_d, pcplus4_d  input  XLEN each  operands
- rs1_d, rs2_d, rd_d  input  5 each  register indices
- forward_ae, forward_be  input  2 each  00 register, 10 alu_result_m, 01 result_w
- result_w  input  XLEN  writeback-stage result
- rs1_e, rs2_e, rd_e  output  5 each  to hazard unit
- resultsrc_e0  output  1  bit 0 of resultsrc_e (load-use detect)
- pcsrc_e  output  1  redirect fetch
- pctarget_e  output  XLEN  branch/jump target
- regwrite_m, memwrite_m  output  1 each  EX/MEM controls
- resultsrc_m  output  2
- alu_result_m, write_data_m, pcplus4_m  output  XLEN each
- rd_m  output  5

Behaviour:
- Reset (async, rst_n=0): every ID/EX and EX/MEM field clears to 0, so all outputs are 0 and pcsrc_e=0. Deassertion takes effect at the first rising edge after rst_n=1. Reset mid-operation discards in-flight instructions with no partial writes.
- ID/EX update at posedge:
  - flush_e=1: load a bubble (all control fields and indices 0; data fields don't-care, implemented as 0).
  - else stall_e=1: hold current contents.
  - else: capture the *_d inputs.
  - flush_e has priority over stall_e.
- EX/MEM update at posedge: always captures the E-stage values (no stall or flush input). A bubble propagates as regwrite_m=0 and memwrite_m=0.
- Forwarding, combinational in E: srca = mux(forward_ae) over {rd1_e, result_w, alu_result_m}; code 11 selects rd1_e. write_data = same mux on forward_be over rd2_e.
- srcb = alusrc_e ? imm_e : write_data.
- ALU, combinational, XLEN-bit, wrap-around arithmetic, no overflow flag:
  - ADD a+b; SUB a-b; AND, OR, XOR bitwise.
  - SLT: signed compare, result {0…,1} when a<b, else 0.
  - Codes 110 and 111 produce 0.
- zero = (alu_result == 0).
- pctarget_e = pc_e + imm_e (wraps).
- pcsrc_e = (branch_e & zero) | jump_e. This is combinational from the ID/EX register, so it is 0 for bubbles.
- Latency: inputs captured at edge N appear on alu_result_m after edge N+1, i.e. 2 edges from decode to memory stage.
- write_data_m is the forwarded rd2 value, not srcb.
- A stalled ID/EX re-presents the same instruction each cycle, so EX/MEM captures a duplicate. The hazard unit must pair stall_e only with an upstream flush policy; this block does not suppress duplicates.

Test Plan:
- Reset mid-stream: rst_n low while regwrite_d=1 → regwrite_m=0, alu_result_m=0, pcsrc_e=0 immediately, without waiting for a clock edge.
- ADD with forwarding: rd1_d=5, rd2_d=0, alucontrol=000, forward_ae=00, forward_be=10, alu_result_m=7 → alu_result_m=12 two edges later.
- BEQ taken: rd1=rd2=0x1234, alucontrol=001, branch_d=1, pc_d=0x100, imm_d=0x20 → in E: pcsrc_e=1, pctarget_e=0x120. Same stimulus with rd2=0x1235 → pcsrc_e=0.
- SLT signed: a=0xFFFFFFFF, b=1, alusrc=0 → alu_result=1. Swap operands → 0. XOR 0xF0F0^0x0FF0 → 0xFF00. Code 111 → 0.
- Stall/flush priority:
  - stall_e=1 for 2 cycles → rd_e and alucontrol held.
  - stall_e=1 with flush_e=1 → bubble, regwrite_m=0 next edge.
  - jump_d=1 then flush → pcsrc_e=0.
- Immediate path: alusrc_d=1, imm_d=0xFFFFFFFC, rd1=8, ADD → alu_result_m=4. write_data_m equals the forwarded rd2, not imm.
